interrupt_arbiter: RTL and testbench
====================================

Name: interrupt_arbiter

Overview:
- Multi-source interrupt front end for processor_16.
- Latches rising edges from N_SRC peripheral interrupt lines, applies a software mask and picks one source with rotating priority.
- Drives the processor's single IRQ line and supplies the 12-bit ISR start address.
- Tracks the ack/return handshake so only one source is in service at a time (no nesting).

Parameters:
- N_SRC, 4, number of interrupt sources (2..8); source index width IDW = clog2(N_SRC).
- ISR_BASE, 12'h100, ISR address for source 0.
- VEC_STRIDE, 12'h010, address spacing between consecutive source ISRs.
- MASK_RESET, all ones, mask value loaded at reset (1 = enabled).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clock.
- irq_src  in  N_SRC  peripheral interrupt lines; level input, rising edge = request.
- cfg_write  in  1  loads cfg_mask into the mask register this cycle.
- cfg_mask  in  N_SRC  new mask value.
- irq_ack  in  1  one-cycle pulse: processor has branched to the ISR (branch_ISR).
- irq_done  in  1  one-cycle pulse: processor executed RTI.
- IRQ  out  1  interrupt request to processor; registered.
- ISR_adr  out  12  ISR start address of the active source; registered.
- active_id  out  IDW  index of the source being requested or serviced.
- busy  out  1  high in REQUEST or SERVICE.
- pending  out  N_SRC  raw pending register, unmasked.

Behaviour:
- Reset (reset_n=0 at an edge):
  - pending=0, src_q=0, mask=MASK_RESET, ptr=0, state=IDLE.
  - IRQ=0, ISR_adr=ISR_BASE, active_id=0, busy=0.
  - Reset mid-operation abandons any request or service; no ack is required afterwards.
- Edge detect: src_q <= irq_src each cycle. pending[i] sets at the edge where irq_src[i]=1 and src_q[i]=0.
- Pending clear: pending[i] clears only on an accepted ack for i. If a set and a clear of the same bit fall in the same cycle, set wins.
- Masking:
  - Masked sources still latch pending but are not eligible.
  - cfg_write is accepted in any state and takes effect from the next cycle.
- FSM states are IDLE, REQUEST and SERVICE.
- IDLE:
  - eligible = pending & mask.
  - If eligible != 0, the winner is the first set bit scanning from ptr upward, wrapping mod N_SRC.
  - On a winner: active_id <= winner, ISR_adr <= ISR_BASE + winner*VEC_STRIDE (mod 4096), IRQ <= 1, go to REQUEST.
- REQUEST:
  - IRQ held at 1, ISR_adr stable.
  - irq_ack: clear pending[active_id], IRQ <= 0, go to SERVICE.
  - Otherwise, if mask[active_id]=0 (mask already updated): IRQ <= 0, go to IDLE (request withdrawn, pending kept).
  - If ack and mask removal coincide, ack wins.
- SERVICE:
  - IRQ=0.
  - irq_done: ptr <= (active_id+1) mod N_SRC, go to IDLE.
  - New edges keep latching into pending during SERVICE.
- Ignored events: irq_ack outside REQUEST and irq_done outside SERVICE have no effect.
- Latency: a rising edge first sampled at edge k sets pending after k; IRQ is high after edge k+1 (2 cycles). After irq_done at edge m, the next IRQ can rise after edge m+1.
- Fairness: the rotating ptr guarantees every continuously pending, enabled source is served within N_SRC service rounds.

Test Plan:
- Reset with irq_src=0 then a single rise on src2 -> IRQ=1 two edges later, ISR_adr=12'h120, active_id=2. Pulse irq_ack -> IRQ=0 next cycle, pending[2]=0. Pulse irq_done -> busy=0.
- src0 and src3 rise in the same cycle, ptr=0 -> serve 0 (ISR_adr 12'h100), then after done serve 3 (12'h130); ptr ends at 0.
- src1 rises repeatedly alongside src2 -> grants alternate 1,2,1,2; neither source is starved.
- cfg_mask=4'b1011 then src2 rises -> pending[2]=1, IRQ stays 0. cfg_mask=4'b1111 -> IRQ=1 two cycles later with ISR_adr=12'h120.
- In REQUEST for src1, write mask clearing bit1 -> IRQ=0 next cycle, state IDLE, pending[1] still 1. Repeat with the mask write and irq_ack in the same cycle -> ack accepted, enters SERVICE.
- reset_n=0 during SERVICE -> all outputs at reset values next cycle. A stray irq_done in IDLE and irq_ack in SERVICE cause no state change.

Source files
------------

// File: rtl/interrupt_arbiter.sv
// Interrupt front end for processor_16: latches rising edges on the peripheral lines, masks them,
// picks one source with rotating priority and tracks the single-level ack/RTI handshake.
module interrupt_arbiter #(
  parameter int unsigned        N_SRC      = 4,
  parameter logic [11:0]        ISR_BASE   = 12'h100,
  parameter logic [11:0]        VEC_STRIDE = 12'h010,
  parameter logic [N_SRC-1:0]   MASK_RESET = '1,
  localparam int unsigned       IDW        = $clog2(N_SRC)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             cfg_write,
  input  logic [N_SRC-1:0] cfg_mask,
  input  logic             irq_ack,
  input  logic             irq_done,
  output logic             IRQ,
  output logic [11:0]      ISR_adr,
  output logic [IDW-1:0]   active_id,
  output logic             busy,
  output logic [N_SRC-1:0] pending
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRequest = 2'd1,
    StService = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [N_SRC-1:0] r_src_q;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] w_pending_d;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] w_mask_d;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   w_ptr_d;
  logic             r_irq;
  logic             w_irq_d;
  logic [11:0]      r_isr_adr;
  logic [11:0]      w_isr_adr_d;
  logic [IDW-1:0]   r_active_id;
  logic [IDW-1:0]   w_active_id_d;

  logic [N_SRC-1:0] w_eligible;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_clr;
  logic             w_ack_ok;
  logic [IDW:0]     w_pick;
  logic             w_found;
  logic [IDW-1:0]   w_winner;
  logic [11:0]      w_vec_adr;

  // First set bit of elig scanning upward from ptr with wrap; MSB of the result flags a hit.
  function automatic logic [IDW:0] pick_winner(input logic [N_SRC-1:0] elig,
                                               input logic [IDW-1:0]   ptr);
    logic [IDW:0]   res;
    logic [IDW-1:0] cand;
    res = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      cand = IDW'((32'(ptr) + i) % N_SRC);
      if (!res[IDW] && elig[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  assign w_eligible = r_pending & r_mask;
  assign w_pick     = pick_winner(w_eligible, r_ptr);
  assign w_found    = w_pick[IDW];
  assign w_winner   = w_pick[IDW-1:0];
  assign w_vec_adr  = ISR_BASE + 12'(w_winner) * VEC_STRIDE;

  assign w_rise = irq_src & ~r_src_q;
  assign w_clr  = w_ack_ok ? ({{(N_SRC-1){1'b0}}, 1'b1} << r_active_id) : '0;

  // A new edge in the same cycle as the clear keeps the bit set.
  assign w_pending_d = (r_pending & ~w_clr) | w_rise;
  assign w_mask_d    = cfg_write ? cfg_mask : r_mask;

  always_comb begin
    w_state_d     = r_state;
    w_irq_d       = r_irq;
    w_isr_adr_d   = r_isr_adr;
    w_active_id_d = r_active_id;
    w_ptr_d       = r_ptr;
    w_ack_ok      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_active_id_d = w_winner;
          w_isr_adr_d   = w_vec_adr;
          w_irq_d       = 1'b1;
          w_state_d     = StRequest;
        end
      end
      StRequest: begin
        if (irq_ack) begin
          w_ack_ok  = 1'b1;
          w_irq_d   = 1'b0;
          w_state_d = StService;
        end else if (!r_mask[r_active_id]) begin
          // Source masked while waiting: withdraw, leave its pending bit for later.
          w_irq_d   = 1'b0;
          w_state_d = StIdle;
        end
      end
      StService: begin
        w_irq_d = 1'b0;
        if (irq_done) begin
          w_ptr_d   = (r_active_id == IDW'(N_SRC - 1)) ? '0 : r_active_id + 1'b1;
          w_state_d = StIdle;
        end
      end
      default: begin
        w_irq_d   = 1'b0;
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_src_q     <= '0;
      r_pending   <= '0;
      r_mask      <= MASK_RESET;
      r_ptr       <= '0;
      r_irq       <= 1'b0;
      r_isr_adr   <= ISR_BASE;
      r_active_id <= '0;
    end else begin
      r_state     <= w_state_d;
      r_src_q     <= irq_src;
      r_pending   <= w_pending_d;
      r_mask      <= w_mask_d;
      r_ptr       <= w_ptr_d;
      r_irq       <= w_irq_d;
      r_isr_adr   <= w_isr_adr_d;
      r_active_id <= w_active_id_d;
    end
  end

  assign IRQ       = r_irq;
  assign ISR_adr   = r_isr_adr;
  assign active_id = r_active_id;
  assign busy      = (r_state != StIdle);
  assign pending   = r_pending;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Self-checking bench for interrupt_arbiter: expected grants are queued as stimulus is driven
// and compared whenever IRQ rises; handshake timing is checked inline.
module tb_interrupt_arbiter;

  localparam int unsigned N = 4;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [N-1:0] irq_src;
  logic         cfg_write;
  logic [N-1:0] cfg_mask;
  logic         irq_ack;
  logic         irq_done;
  logic         IRQ;
  logic [11:0]  ISR_adr;
  logic [1:0]   active_id;
  logic         busy;
  logic [N-1:0] pending;

  interrupt_arbiter #(
    .N_SRC      (N),
    .ISR_BASE   (12'h100),
    .VEC_STRIDE (12'h010),
    .MASK_RESET (4'b1111)
  ) u_dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .irq_src   (irq_src),
    .cfg_write (cfg_write),
    .cfg_mask  (cfg_mask),
    .irq_ack   (irq_ack),
    .irq_done  (irq_done),
    .IRQ       (IRQ),
    .ISR_adr   (ISR_adr),
    .active_id (active_id),
    .busy      (busy),
    .pending   (pending)
  );

  always #5 clock = ~clock;

  typedef struct {
    int id;
    int adr;
  } grant_t;

  grant_t exp_q[$];
  grant_t g;
  int     n_checks = 0;
  int     n_pass   = 0;
  logic   prev_irq = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Scoreboard: every rising IRQ must match the oldest queued grant.
  always @(negedge clock) begin
    if (IRQ === 1'b1 && prev_irq !== 1'b1) begin
      check("grant_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        g = exp_q.pop_front();
        check("grant_id", 32'(active_id), g.id);
        check("grant_adr", 32'(ISR_adr), g.adr);
      end
    end
    prev_irq = IRQ;
  end

  task automatic expect_grant(input int id);
    grant_t e;
    e.id  = id;
    e.adr = 'h100 + id * 'h10;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_src(input logic [N-1:0] s);
    irq_src = s;
    step();
    irq_src = '0;
    step();
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    cfg_write = 1'b1;
    cfg_mask  = m;
    step();
    cfg_write = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_irq"}, IRQ, 0);
    check({tag, "_adr"}, ISR_adr, 'h100);
    check({tag, "_id"}, active_id, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pend"}, pending, 0);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    irq_src   = '0;
    cfg_write = 1'b0;
    cfg_mask  = '0;
    irq_ack   = 1'b0;
    irq_done  = 1'b0;
    step(2);
    check_reset_vals("reset");
    reset_n = 1'b1;
    step();
  endtask

  task automatic wait_irq();
    for (int i = 0; i < 8 && IRQ !== 1'b1; i++) step();
    check("irq_raised", IRQ, 1);
  endtask

  task automatic serve(input int id, input logic [N-1:0] repulse);
    wait_irq();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("ack_irq_low", IRQ, 0);
    check("ack_busy", busy, 1);
    check("ack_clr", pending[id], 0);
    if (repulse != '0) begin
      pulse_src(repulse);
      check("svc_latch", pending & repulse, repulse);
    end
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    check("done_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single source, exact latency and handshake, stray events.
    do_reset();
    expect_grant(2);
    irq_src = 4'b0100;
    step();
    check("t1_pend_set", pending, 4'b0100);
    check("t1_irq_early", IRQ, 0);
    step();
    check("t1_irq", IRQ, 1);
    check("t1_busy", busy, 1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("t1_ack_irq", IRQ, 0);
    check("t1_ack_pend", pending, 0);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("t1_stray_ack_busy", busy, 1);
    check("t1_stray_ack_irq", IRQ, 0);
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    check("t1_done_busy", busy, 0);
    irq_src  = '0;
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    check("t1_stray_done_busy", busy, 0);
    check("t1_stray_done_irq", IRQ, 0);

    // Simultaneous rise on 0 and 3 from ptr=0.
    do_reset();
    expect_grant(0);
    expect_grant(3);
    irq_src = 4'b1001;
    step();
    irq_src = '0;
    serve(0, '0);
    serve(3, '0);

    // Repeated rises on 1 and 2 alternate.
    expect_grant(1);
    expect_grant(2);
    expect_grant(1);
    expect_grant(2);
    pulse_src(4'b0110);
    serve(1, 4'b0110);
    serve(2, 4'b0110);
    serve(1, '0);
    serve(2, '0);

    // Masked source latches but is not requested until unmasked.
    write_mask(4'b1011);
    pulse_src(4'b0100);
    check("t4_pend_masked", pending[2], 1);
    check("t4_irq_masked", IRQ, 0);
    step(2);
    check("t4_irq_still_low", IRQ, 0);
    expect_grant(2);
    write_mask(4'b1111);
    check("t4_irq_unmask_early", IRQ, 0);
    step();
    check("t4_irq_unmask", IRQ, 1);
    serve(2, '0);

    // Withdrawal by mask, then ack racing a cleared mask.
    expect_grant(1);
    pulse_src(4'b0010);
    check("t5_irq", IRQ, 1);
    write_mask(4'b1101);
    check("t5_irq_before_mask", IRQ, 1);
    step();
    check("t5_withdraw_irq", IRQ, 0);
    check("t5_withdraw_busy", busy, 0);
    check("t5_withdraw_pend", pending[1], 1);
    step();
    check("t5_masked_idle", IRQ, 0);
    expect_grant(1);
    write_mask(4'b1111);
    check("t5_rereq_early", IRQ, 0);
    step();
    check("t5_rereq", IRQ, 1);
    write_mask(4'b1101);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("t5_ack_wins_irq", IRQ, 0);
    check("t5_ack_wins_busy", busy, 1);
    check("t5_ack_wins_pend", pending[1], 0);
    write_mask(4'b1111);
    irq_done = 1'b1;
    step();
    irq_done = 1'b0;
    check("t5_done_busy", busy, 0);

    // Reset during service abandons it; ptr returns to 0.
    expect_grant(0);
    pulse_src(4'b0001);
    wait_irq();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("t6_service", busy, 1);
    pulse_src(4'b1000);
    check("t6_pend3", pending[3], 1);
    reset_n = 1'b0;
    step();
    check_reset_vals("t6_midreset");
    reset_n = 1'b1;
    step();
    check("t6_post_reset_irq", IRQ, 0);
    expect_grant(1);
    expect_grant(3);
    irq_src = 4'b1010;
    step();
    irq_src = '0;
    serve(1, '0);
    serve(3, '0);

    step(2);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
